// File: rtl/tmds_decoder_pkg.sv
// Shared video definitions: TMDS control tokens
// and the word-alignment state encoding.
package tmds_decoder_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP_WAIT,
    LOCKED
  } align_state_e;

endpackage

// File: rtl/tmds_decoder_if.sv
// TMDS channel bundle between deserializer side
// (master) and the channel decoder (slave).
interface tmds_decoder_if;

  logic [9:0] tmds;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic       bitslip;
  logic       ctrl_err;

  modport master (
    output tmds,
    input  data,
    input  ctrl,
    input  de,
    input  locked,
    input  bitslip,
    input  ctrl_err
  );

  modport slave (
    input  tmds,
    output data,
    output ctrl,
    output de,
    output locked,
    output bitslip,
    output ctrl_err
  );

endinterface

// File: rtl/tmds_char_decode.sv
// Combinational TMDS character decode:
// 10-bit word -> control flag, ctrl bits, pixel byte.
module tmds_char_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] tmds_i,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] q;

  // Token match against the four control symbols.
  always_comb begin
    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    unique case (1'b1)
      (tmds_i == CTRL_TOKEN_00): ctrl_o = 2'b00;
      (tmds_i == CTRL_TOKEN_01): ctrl_o = 2'b01;
      (tmds_i == CTRL_TOKEN_10): ctrl_o = 2'b10;
      (tmds_i == CTRL_TOKEN_11): ctrl_o = 2'b11;
      default:                   is_ctrl_o = 1'b0;
    endcase
  end

  // Undo DC-balance inversion, then XOR/XNOR chain.
  always_comb begin
    q      = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
    data_o = 8'h00;
    data_o[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = tmds_i[8] ? (q[i] ^ q[i-1])
                            : (q[i] ~^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with registered decode
// and control-token word-alignment FSM.
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input logic clk,
  input logic rst_n,
  tmds_decoder_if.slave bus
);

  localparam int TMAX =
    (SEARCH_TIMEOUT > LOSS_TIMEOUT) ?
    SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TKW = $clog2(LOCK_COUNT) + 1;
  localparam int TMW = $clog2(TMAX) + 1;
  localparam int STW = $clog2(SLIP_SETTLE) + 1;

  localparam logic [TKW-1:0] TOK_LAST =
    TKW'(LOCK_COUNT - 1);
  localparam logic [TMW-1:0] SRCH_LAST =
    TMW'(SEARCH_TIMEOUT - 1);
  localparam logic [TMW-1:0] LOSS_LAST =
    TMW'(LOSS_TIMEOUT - 1);
  localparam logic [STW-1:0] SET_LAST =
    STW'(SLIP_SETTLE - 1);

  logic       is_ctrl;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;

  tmds_char_decode u_dec (
    .tmds_i    (bus.tmds),
    .is_ctrl_o (is_ctrl),
    .ctrl_o    (dec_ctrl),
    .data_o    (dec_data)
  );

  logic [7:0]   data_q;
  logic [1:0]   ctrl_q;
  logic         de_q;
  align_state_e state_q, state_d;
  logic [TKW-1:0] tok_q, tok_d;
  logic [TMW-1:0] tim_q, tim_d;
  logic [STW-1:0] set_q, set_d;
  logic         locked_q, locked_d;
  logic         slip_q, slip_d;
  logic         err_q, err_d;

  // Output registers: data holds on tokens, ctrl holds on data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      ctrl_q <= 2'b00;
      de_q   <= 1'b0;
    end else if (is_ctrl) begin
      ctrl_q <= dec_ctrl;
      de_q   <= 1'b0;
    end else begin
      data_q <= dec_data;
      de_q   <= 1'b1;
    end
  end

  // Alignment FSM and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      tok_q    <= '0;
      tim_q    <= '0;
      set_q    <= '0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tok_q    <= tok_d;
      tim_q    <= tim_d;
      set_q    <= set_d;
      locked_q <= locked_d;
      slip_q   <= slip_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; completing a lock beats the slip timeout.
  always_comb begin
    state_d  = state_q;
    tok_d    = tok_q;
    tim_d    = tim_q;
    set_d    = set_q;
    locked_d = locked_q;
    slip_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        tim_d = tim_q + 1'b1;
        if (is_ctrl) begin
          tok_d = tok_q + 1'b1;
        end else begin
          tok_d = '0;
          err_d = (tok_q != '0);
        end
        if (is_ctrl && tok_q == TOK_LAST) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          tim_d    = '0;
          tok_d    = '0;
        end else if (tim_q == SRCH_LAST) begin
          state_d = SLIP_WAIT;
          slip_d  = 1'b1;
          tim_d   = '0;
          tok_d   = '0;
          set_d   = '0;
        end
      end
      SLIP_WAIT: begin
        set_d = set_q + 1'b1;
        if (set_q == SET_LAST) begin
          state_d = SEARCH;
          set_d   = '0;
          tok_d   = '0;
          tim_d   = '0;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          tim_d = '0;
        end else if (tim_q == LOSS_LAST) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          tim_d    = '0;
          tok_d    = '0;
        end else begin
          tim_d = tim_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign bus.data     = data_q;
  assign bus.ctrl     = ctrl_q;
  assign bus.de       = de_q;
  assign bus.locked   = locked_q;
  assign bus.bitslip  = slip_q;
  assign bus.ctrl_err = err_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed vectors,
// encoder round-trip, slip alignment, loss and reset.
module tb_tmds_decoder;
  import tmds_decoder_pkg::*;

  typedef struct {
    logic       chk;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  tmds_decoder_if bus();

  tmds_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb[$];
  int         nchk = 0;
  int         nerr = 0;
  int         rd = 0;
  logic [7:0] last_d;
  logic [1:0] last_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n,
                       input logic [31:0] a,
                       input logic [31:0] x);
    nchk++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w,
                                      input int r);
    logic [9:0] o;
    o = (w << r) | (w >> (10 - r));
    return o;
  endfunction

  // Reference DVI encoder with running disparity.
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (rd == 0 || n1q == n0q) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      rd += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((rd > 0 && n1q > n0q) ||
                 (rd < 0 && n0q > n1q)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      rd += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      rd += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return o;
  endfunction

  task automatic put(input logic [9:0] w, input exp_t e);
    bus.tmds = w;
    sb.push_back(e);
  endtask

  task automatic send_tok(input logic [1:0] c,
                          input logic lk);
    exp_t e;
    e = '{chk: 1'b1, de: 1'b0, data: last_d,
          ctrl: c, locked: lk, err: 1'b0};
    @(negedge clk);
    put(tok(c), e);
    last_c = c;
    rd = 0;
  endtask

  task automatic send_dat(input logic [9:0] w,
                          input logic [7:0] d,
                          input logic lk,
                          input logic er);
    exp_t e;
    e = '{chk: 1'b1, de: 1'b1, data: d,
          ctrl: last_c, locked: lk, err: er};
    @(negedge clk);
    put(w, e);
    last_d = d;
  endtask

  function automatic exp_t nochk();
    exp_t e;
    e = '{chk: 1'b0, de: 1'b0, data: 8'h00,
          ctrl: 2'b00, locked: 1'b0, err: 1'b0};
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.tmds = 10'h000;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", bus.data, 0);
    check("rst_ctrl", bus.ctrl, 0);
    check("rst_de", bus.de, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_bitslip", bus.bitslip, 0);
    check("rst_ctrl_err", bus.ctrl_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    last_d = 8'h00;
    last_c = 2'b00;
    rd = 0;
  endtask

  // Monitor: one scoreboard entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("de", bus.de, e.de);
          check("data", bus.data, e.data);
          check("ctrl", bus.ctrl, e.ctrl);
          check("locked", bus.locked, e.locked);
          check("ctrl_err", bus.ctrl_err, e.err);
          check("bitslip", bus.bitslip, 0);
        end
      end
    end
  end

  initial begin
    int rot, n, nslip, last_slip;
    logic seen;

    do_reset();

    // Partial token run broken by data -> ctrl_err pulse.
    for (int k = 0; k < 3; k++) send_tok(2'b00, 1'b0);
    send_dat(10'b0100000000, 8'h00, 1'b0, 1'b1);
    send_dat(10'b1000000000, 8'hFF, 1'b0, 1'b0);

    // Lock on the eighth consecutive token.
    for (int k = 1; k <= 10; k++)
      send_tok(2'b00, k >= 8);

    send_dat(10'b0100000000, 8'h00, 1'b1, 1'b0);
    send_dat(10'b1000000000, 8'hFF, 1'b1, 1'b0);
    send_dat(10'b0111111111, 8'h01, 1'b1, 1'b0);
    send_tok(2'b01, 1'b1);

    // Encoder round-trip of every byte and control value.
    for (int b = 0; b < 256; b++) begin
      if (b % 64 == 0)
        for (int c = 0; c < 4; c++) send_tok(2'(c), 1'b1);
      send_dat(enc(8'(b)), 8'(b), 1'b1, 1'b0);
    end

    // Loss of lock after LOSS_TIMEOUT data words.
    send_tok(2'b00, 1'b1);
    for (int i = 1; i <= 4096; i++)
      send_dat(10'b0100000000, 8'h00, i < 4096, 1'b0);
    send_dat(10'b1000000000, 8'hFF, 1'b0, 1'b0);

    // Misaligned stream: bench rotates one bit per slip.
    do_reset();
    rot = 3;
    n = 0;
    nslip = 0;
    last_slip = 0;
    while (!bus.locked && n < 40000) begin
      @(negedge clk);
      n++;
      if (bus.bitslip) begin
        nslip++;
        if (nslip == 1) check("first_slip", n, 4097);
        else check("slip_gap", n - last_slip, 4100);
        last_slip = n;
        rot = (rot + 1) % 10;
      end
      if (!bus.locked) put(rotl(CTRL_TOKEN_00, rot), nochk());
    end
    check("slip_count", nslip, 7);
    check("slip_locked", bus.locked, 1);
    repeat (2) @(posedge clk);

    // Asynchronous reset while a slip pulse is visible.
    do_reset();
    rot = 3;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      if (bus.bitslip) seen = 1'b1;
      else put(rotl(CTRL_TOKEN_00, rot), nochk());
    end
    check("rst_slip_seen", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_bitslip", bus.bitslip, 0);
    check("arst_locked", bus.locked, 0);
    check("arst_de", bus.de, 0);
    check("arst_data", bus.data, 0);
    check("arst_ctrl", bus.ctrl, 0);
    check("arst_ctrl_err", bus.ctrl_err, 0);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    last_d = 8'h00;
    last_c = 2'b00;
    for (int k = 1; k <= 9; k++)
      send_tok(2'b10, k >= 8);
    send_dat(10'b0111111111, 8'h01, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
